// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the button conditioner: per-key FSM state
// encoding and default debounce/auto-repeat periods (50 MHz system clock).
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int REPEAT_DEFAULT   = 12500000;

    // The key counts as pressed once a press is accepted until a release is accepted.
    function automatic logic is_down(input btn_state_t s);
        return (s == HELD) || (s == REL_CHK);
    endfunction

endpackage

// File: rtl/debounce_fsm.sv
// One key: 2-flop synchronizer, debounce FSM with saturating counter, and an
// optional auto-repeat strobe generator selected by REPEAT_EN.
module debounce_fsm
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_DEFAULT,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic db_n,
    output logic pulse
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] THRESH = CW'(DEBOUNCE_CYCLES);

    logic          sync_p0;
    logic          sync_p1;
    btn_state_t    state;
    btn_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          db_next;
    logic          press_next;
    logic          press_pulse;
    logic          rpt_fire;

    // Synchronizer idles high so a reset looks like a released key.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= raw_n;
            sync_p1 <= sync_p0;
        end
    end

    assign cnt_inc = (cnt == THRESH) ? cnt : cnt + CW'(1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (!sync_p1) state_next = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (sync_p1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_inc == THRESH) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HELD: begin
                if (sync_p1) state_next = REL_CHK;
            end
            REL_CHK: begin
                if (!sync_p1) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_inc == THRESH) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        db_next    = !is_down(state_next);
        press_next = (state == PRESS_CHK) && (state_next == HELD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            db_n        <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            db_n        <= db_next;
            press_pulse <= press_next;
        end
    end

    // Repeat counter runs only in HELD; the first repeat lands REPEAT_CYCLES after the press strobe.
    generate
        if (REPEAT_EN && (REPEAT_CYCLES > 0)) begin : g_repeat
            localparam int            RW    = $clog2(REPEAT_CYCLES + 1);
            localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
            logic [RW-1:0] rpt_cnt;

            always_ff @(posedge clk) begin
                if (rst || (state != HELD)) begin
                    rpt_cnt  <= '0;
                    rpt_fire <= 1'b0;
                end else if (rpt_cnt == RLAST) begin
                    rpt_cnt  <= '0;
                    rpt_fire <= 1'b1;
                end else begin
                    rpt_cnt  <= rpt_cnt + RW'(1);
                    rpt_fire <= 1'b0;
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire = 1'b0;
        end
    endgenerate

    assign pulse = press_pulse | rpt_fire;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the Run and Continue keys and synchronizes the slide switches.
// Define BTN_COND_AUTOREPEAT_EN to make a held Continue key re-strobe every REPEAT_CYCLES.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_raw_n,
    input  logic       Continue_raw_n,
    input  logic [9:0] SW_raw,
    output logic       Run_n,
    output logic       Continue_n,
    output logic       Run_pulse,
    output logic       Continue_pulse,
    output logic [9:0] SW_sync
);

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam bit CONT_REPEAT_EN = 1'b1;
`else
    localparam bit CONT_REPEAT_EN = 1'b0;
`endif

    logic [9:0] sw_p0;
    logic [9:0] sw_p1;

    // Switches are level inputs to software, so they are only synchronized.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= SW_raw;
            sw_p1 <= sw_p0;
        end
    end

    assign SW_sync = sw_p1;

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_run (
        .clk   (Clk),
        .rst   (Reset),
        .raw_n (Run_raw_n),
        .db_n  (Run_n),
        .pulse (Run_pulse)
    );

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (CONT_REPEAT_EN)
    ) u_continue (
        .clk   (Clk),
        .rst   (Reset),
        .raw_n (Continue_raw_n),
        .db_n  (Continue_n),
        .pulse (Continue_pulse)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Stimulus queues expected levels and pulse cycles; a negedge monitor checks them.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int REP = 8;

    localparam int S_RUN_N  = 0;
    localparam int S_CONT_N = 1;
    localparam int S_RUN_P  = 2;
    localparam int S_CONT_P = 3;
    localparam int S_SW     = 4;

    logic       Clk            = 1'b0;
    logic       Reset          = 1'b1;
    logic       Run_raw_n      = 1'b1;
    logic       Continue_raw_n = 1'b1;
    logic [9:0] SW_raw         = 10'h155;
    logic       Run_n;
    logic       Continue_n;
    logic       Run_pulse;
    logic       Continue_pulse;
    logic [9:0] SW_sync;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run_raw_n      (Run_raw_n),
        .Continue_raw_n (Continue_raw_n),
        .SW_raw         (SW_raw),
        .Run_n          (Run_n),
        .Continue_n     (Continue_n),
        .Run_pulse      (Run_pulse),
        .Continue_pulse (Continue_pulse),
        .SW_sync        (SW_sync)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         sig;
        logic [9:0] val;
    } exp_t;

    exp_t lvl_q[$];
    int   run_q[$];
    int   cont_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [9:0] sig_val(input int s);
        case (s)
            S_RUN_N:  return {9'd0, Run_n};
            S_CONT_N: return {9'd0, Continue_n};
            S_RUN_P:  return {9'd0, Run_pulse};
            S_CONT_P: return {9'd0, Continue_pulse};
            default:  return SW_sync;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_RUN_N:  return "Run_n";
            S_CONT_N: return "Continue_n";
            S_RUN_P:  return "Run_pulse";
            S_CONT_P: return "Continue_pulse";
            default:  return "SW_sync";
        endcase
    endfunction

    task automatic expect_lvl(input int c, input int s, input logic [9:0] v);
        lvl_q.push_back('{cyc: c, sig: s, val: v});
    endtask

    task automatic expect_reset_state(input int c);
        expect_lvl(c, S_RUN_N, 10'd1);
        expect_lvl(c, S_CONT_N, 10'd1);
        expect_lvl(c, S_RUN_P, 10'd0);
        expect_lvl(c, S_CONT_P, 10'd0);
        expect_lvl(c, S_SW, 10'd0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: pulses are matched against queued cycle numbers, levels against queued samples.
    always @(negedge Clk) begin : monitor
        int e;
        if (Run_pulse) begin
            checks++;
            if (run_q.size() == 0) begin
                errors++;
                $display("FAIL run_pulse: unexpected pulse at cycle %0d, none queued", cyc);
            end else begin
                e = run_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL run_pulse: pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
        if (Continue_pulse) begin
            checks++;
            if (cont_q.size() == 0) begin
                errors++;
                $display("FAIL continue_pulse: unexpected pulse at cycle %0d, none queued", cyc);
            end else begin
                e = cont_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL continue_pulse: pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
        for (int i = lvl_q.size() - 1; i >= 0; i--) begin
            if (lvl_q[i].cyc == cyc) begin
                checks++;
                if (sig_val(lvl_q[i].sig) !== lvl_q[i].val) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h",
                             sig_name(lvl_q[i].sig), cyc, sig_val(lvl_q[i].sig), lvl_q[i].val);
                end
                lvl_q.delete(i);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c0;
        int c1;
        int d;

        // Reset state while the switches are already non-zero.
        step(3);
        expect_reset_state(cyc);
        Reset = 1'b0;
        expect_lvl(cyc + 1, S_SW, 10'h000);
        expect_lvl(cyc + 2, S_SW, 10'h155);
        step(5);

        // Run press held 20 cycles: strobe and level fall at +7, level rises 7 after release.
        c0 = cyc;
        Run_raw_n = 1'b0;
        expect_lvl(c0 + 6, S_RUN_N, 10'd1);
        expect_lvl(c0 + 7, S_RUN_N, 10'd0);
        expect_lvl(c0 + 7, S_RUN_P, 10'd1);
        expect_lvl(c0 + 8, S_RUN_P, 10'd0);
        run_q.push_back(c0 + 7);
        step(20);
        c1 = cyc;
        Run_raw_n = 1'b1;
        expect_lvl(c1 + 6, S_RUN_N, 10'd0);
        expect_lvl(c1 + 7, S_RUN_N, 10'd1);
        step(12);

        // Continue bouncing every 2 cycles never debounces.
        for (int i = 0; i < 30; i++) begin
            Continue_raw_n = ((i / 2) % 2) != 0;
            expect_lvl(cyc, S_CONT_N, 10'd1);
            step(1);
        end
        Continue_raw_n = 1'b1;
        for (int i = 0; i < 6; i++) expect_lvl(cyc + i, S_CONT_N, 10'd1);
        step(10);

        // Both keys on the same edge strobe in the same cycle.
        c0 = cyc;
        Run_raw_n = 1'b0;
        Continue_raw_n = 1'b0;
        run_q.push_back(c0 + 7);
        cont_q.push_back(c0 + 7);
        expect_lvl(c0 + 7, S_RUN_P, 10'd1);
        expect_lvl(c0 + 7, S_CONT_P, 10'd1);
        expect_lvl(c0 + 7, S_CONT_N, 10'd0);
        step(12);
        c1 = cyc;
        Run_raw_n = 1'b1;
        Continue_raw_n = 1'b1;
        expect_lvl(c1 + 7, S_RUN_N, 10'd1);
        expect_lvl(c1 + 7, S_CONT_N, 10'd1);
        step(10);

        // Switch synchronizer latency.
        c0 = cyc;
        SW_raw = 10'h05A;
        expect_lvl(c0 + 1, S_SW, 10'h155);
        expect_lvl(c0 + 2, S_SW, 10'h05A);
        step(2);
        SW_raw = 10'h003;
        expect_lvl(cyc + 1, S_SW, 10'h05A);
        expect_lvl(cyc + 2, S_SW, 10'h003);
        step(4);

        // One-cycle reset while Run is HELD; the still-pressed key debounces again.
        c0 = cyc;
        Run_raw_n = 1'b0;
        run_q.push_back(c0 + 7);
        step(10);
        expect_lvl(cyc, S_RUN_N, 10'd0);
        Reset = 1'b1;
        step(1);
        expect_reset_state(cyc);
        Reset = 1'b0;
        d = cyc;
        expect_lvl(d + 1, S_SW, 10'h000);
        expect_lvl(d + 2, S_SW, 10'h003);
        expect_lvl(d + 6, S_RUN_N, 10'd1);
        expect_lvl(d + 7, S_RUN_N, 10'd0);
        run_q.push_back(d + 7);
        step(12);
        Run_raw_n = 1'b1;
        step(10);

        // Continue held 30 cycles; repeats only in the auto-repeat build.
        c0 = cyc;
        Continue_raw_n = 1'b0;
        cont_q.push_back(c0 + 7);
`ifdef BTN_COND_AUTOREPEAT_EN
        cont_q.push_back(c0 + 15);
        cont_q.push_back(c0 + 23);
        // Sync latency keeps the key in HELD through edge 31 after a 30-cycle hold.
        cont_q.push_back(c0 + 31);
`endif
        expect_lvl(c0 + 16, S_CONT_P, 10'd0);
        step(30);
        Continue_raw_n = 1'b1;
        step(12);

        // Run held the same way never repeats.
        c0 = cyc;
        Run_raw_n = 1'b0;
        run_q.push_back(c0 + 7);
        expect_lvl(c0 + 15, S_RUN_P, 10'd0);
        expect_lvl(c0 + 23, S_RUN_P, 10'd0);
        step(30);
        Run_raw_n = 1'b1;
        step(12);

        checks++;
        if (lvl_q.size() != 0) begin
            errors++;
            $display("FAIL level_queue_drain: %0d samples left, expected 0", lvl_q.size());
        end
        checks++;
        if (run_q.size() != 0) begin
            errors++;
            $display("FAIL run_pulse_missing: %0d pulses not seen, expected 0", run_q.size());
        end
        checks++;
        if (cont_q.size() != 0) begin
            errors++;
            $display("FAIL continue_pulse_missing: %0d pulses not seen, expected 0", cont_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
